// File: rtl/bloom_fw_pkg.sv
// Shared types and hash constants for the Bloom-filter firewall.
// Imported by the hash sub-module, the top level and the bench.
package bloom_fw_pkg;

    typedef enum logic {
        OP_QUERY  = 1'b0,
        OP_INSERT = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        IDLE,
        PROBE,
        RESULT,
        CLEAR
    } state_e;

    typedef struct packed {
        logic [71:0] ip_protocol;
        logic [15:0] src_port;
        logic [15:0] dst_port;
    } flow_key_t;

    localparam logic [31:0] SEED_STEP = 32'h9E3779B9;
    localparam logic [31:0] MIX_MUL   = 32'h045D9F3B;

endpackage

// File: rtl/bloom_filter_firewall_if.sv
// Request/response handshake between the header parser (master) and
// the Bloom-filter firewall (slave).
interface bloom_filter_firewall_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [71:0] ip_protocol;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_hit;

    modport master (
        output req_valid, req_op, ip_protocol, src_port, dst_port, rsp_ready,
        input  req_ready, rsp_valid, rsp_hit
    );

    modport slave (
        input  req_valid, req_op, ip_protocol, src_port, dst_port, rsp_ready,
        output req_ready, rsp_valid, rsp_hit
    );

endinterface

// File: rtl/bloom_hash_idx.sv
// Combinational seeded hash: maps (flow key, probe number) to a bit-array index.
module bloom_hash_idx
    import bloom_fw_pkg::*;
#(
    parameter int IDX_W = 10
) (
    input  flow_key_t        key,
    input  logic [2:0]       probe,
    output logic [IDX_W-1:0] idx
);

    // Each probe number perturbs the key by a golden-ratio step before mixing.
    function automatic logic [IDX_W-1:0] hash_idx(input flow_key_t k, input logic [2:0] i);
        logic [31:0] x;
        x = k.ip_protocol[71:40] ^ k.ip_protocol[39:8] ^ {k.ip_protocol[7:0], 24'h0}
          ^ {k.src_port, k.dst_port} ^ (32'(i) * SEED_STEP);
        x = x ^ (x >> 16);
        x = x * MIX_MUL;
        x = x ^ (x >> 16);
        return x[IDX_W-1:0];
    endfunction

    assign idx = hash_idx(key, probe);

endmodule

// File: rtl/bloom_filter_firewall.sv
// Bloom-filter firewall: QUERY/INSERT flow keys against an M_BITS bit array,
// one hash probe per cycle, with a multi-cycle CLEAR sweep and statistics.
module bloom_filter_firewall
    import bloom_fw_pkg::*;
#(
    parameter  int M_BITS = 1024,
    parameter  int K_HASH = 3,
    parameter  int CLR_W  = 64,
    parameter  int CNT_W  = 32,
    localparam int IDX_W  = $clog2(M_BITS)
) (
    input  logic                   clk,
    input  logic                   reset,
    bloom_filter_firewall_if.slave bus,
    input  logic                   clear_req,
    output logic                   busy,
    output logic [IDX_W:0]         occupancy,
    output logic [CNT_W-1:0]       hit_count,
    output logic [CNT_W-1:0]       insert_count
);

    localparam int N_WORDS = M_BITS / CLR_W;
    localparam int WORD_W  = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
    localparam int CLR_SH  = $clog2(CLR_W);
    localparam logic [WORD_W-1:0] LAST_WORD  = WORD_W'(N_WORDS - 1);
    localparam logic [2:0]        LAST_PROBE = 3'(K_HASH - 1);

    state_e            state_q, next_state;
    flow_key_t         key_q;
    op_e               op_q;
    logic [2:0]        probe_q;
    logic              acc_q;
    logic [M_BITS-1:0] bits_q;
    logic [WORD_W-1:0] word_q;
    logic [IDX_W-1:0]  probe_idx;
    logic [IDX_W-1:0]  clr_base;
    logic              probe_bit;

    bloom_hash_idx #(.IDX_W(IDX_W)) u_hash (
        .key   (key_q),
        .probe (probe_q),
        .idx   (probe_idx)
    );

    assign probe_bit = bits_q[probe_idx];
    assign clr_base  = IDX_W'(word_q) << CLR_SH;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= next_state;
    end

    // NOTE: next_state takes its hold value first so no path through this block infers a latch.
    always_comb begin
        next_state = state_q;
        unique case (state_q)
            IDLE:    if (clear_req)                  next_state = CLEAR;
                     else if (bus.req_valid)         next_state = PROBE;
            PROBE:   if (probe_q == LAST_PROBE)      next_state = RESULT;
            RESULT:  if (bus.rsp_ready)              next_state = IDLE;
            CLEAR:   if (word_q == LAST_WORD)        next_state = IDLE;
            default:                                 next_state = IDLE;
        endcase
    end

    // NOTE: the bit array lives in flops and is reset explicitly, because reset must
    // leave every bit 0 immediately rather than after an M_BITS/CLR_W-cycle sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q        <= '0;
            op_q         <= OP_QUERY;
            probe_q      <= '0;
            acc_q        <= 1'b0;
            bits_q       <= '0;
            word_q       <= '0;
            occupancy    <= '0;
            hit_count    <= '0;
            insert_count <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!clear_req && bus.req_valid) begin
                        key_q   <= '{ip_protocol: bus.ip_protocol,
                                     src_port:    bus.src_port,
                                     dst_port:    bus.dst_port};
                        op_q    <= op_e'(bus.req_op);
                        probe_q <= '0;
                        acc_q   <= 1'b1;
                    end
                end
                PROBE: begin
                    acc_q   <= acc_q & probe_bit;
                    probe_q <= probe_q + 1'b1;
                    if (op_q == OP_INSERT && !probe_bit) begin
                        bits_q[probe_idx] <= 1'b1;
                        occupancy         <= occupancy + 1'b1;
                    end
                end
                RESULT: begin
                    if (bus.rsp_ready) begin
                        if (op_q == OP_QUERY && acc_q) hit_count    <= sat_inc(hit_count);
                        if (op_q == OP_INSERT)         insert_count <= sat_inc(insert_count);
                    end
                end
                CLEAR: begin
                    bits_q[clr_base +: CLR_W] <= '0;
                    if (word_q == LAST_WORD) begin
                        word_q       <= '0;
                        occupancy    <= '0;
                        hit_count    <= '0;
                        insert_count <= '0;
                    end else begin
                        word_q <= word_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESULT);
    assign bus.rsp_hit   = (state_q == RESULT) && acc_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bloom_filter_firewall.sv
// Self-checking bench for bloom_filter_firewall: randomized QUERY/INSERT traffic
// compared against an array-of-bits reference model of the filter.
module tb_bloom_filter_firewall;
    import bloom_fw_pkg::*;

    localparam int M_BITS  = 1024;
    localparam int K_HASH  = 3;
    localparam int CLR_W   = 64;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = $clog2(M_BITS);
    localparam int N_WORDS = M_BITS / CLR_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int LIMIT   = 100;

    logic             clk = 1'b0;
    logic             reset;
    logic             clear_req;
    logic             busy;
    logic [IDX_W:0]   occupancy;
    logic [CNT_W-1:0] hit_count;
    logic [CNT_W-1:0] insert_count;

    bloom_filter_firewall_if bus();

    bloom_filter_firewall #(
        .M_BITS (M_BITS),
        .K_HASH (K_HASH),
        .CLR_W  (CLR_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .clear_req    (clear_req),
        .busy         (busy),
        .occupancy    (occupancy),
        .hit_count    (hit_count),
        .insert_count (insert_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit        model_bits [M_BITS];
    int        model_occ;
    int        model_hits;
    int        model_ins;
    flow_key_t keys [$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference hash written straight from the arithmetic definition.
    function automatic int model_hash(input flow_key_t k, input int i);
        logic [31:0] x;
        x = k.ip_protocol[71:40] ^ k.ip_protocol[39:8] ^ {k.ip_protocol[7:0], 24'h0}
          ^ {k.src_port, k.dst_port} ^ (32'(i) * 32'h9E3779B9);
        x = x ^ (x >> 16);
        x = x * 32'h045D9F3B;
        x = x ^ (x >> 16);
        return int'(x % 32'(M_BITS));
    endfunction

    task automatic model_clear();
        foreach (model_bits[i]) model_bits[i] = 1'b0;
        model_occ  = 0;
        model_hits = 0;
        model_ins  = 0;
    endtask

    // Applies one completed operation to the model and returns the expected hit.
    task automatic model_apply(input bit ins, input flow_key_t k, output bit acc);
        int ix;
        acc = 1'b1;
        for (int i = 0; i < K_HASH; i++) begin
            ix  = model_hash(k, i);
            acc = acc & model_bits[ix];
            if (ins && !model_bits[ix]) begin
                model_bits[ix] = 1'b1;
                model_occ++;
            end
        end
        if (!ins && acc && model_hits < CNT_MAX) model_hits++;
        if (ins && model_ins < CNT_MAX)          model_ins++;
    endtask

    function automatic logic [M_BITS-1:0] model_vec();
        logic [M_BITS-1:0] v;
        foreach (model_bits[i]) v[i] = model_bits[i];
        return v;
    endfunction

    function automatic flow_key_t rand_key();
        flow_key_t k;
        k.ip_protocol = {8'($urandom), 32'($urandom), 32'($urandom)};
        k.src_port    = 16'($urandom);
        k.dst_port    = 16'($urandom);
        return k;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset         = 1'b1;
        clear_req     = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    // Drives one request; lat counts edges from the accepting edge to the first
    // rsp_valid sample (K_HASH expected), stable covers the whole RESULT hold.
    task automatic run_op(input bit ins, input flow_key_t k, input int hold, input bit early_ready,
                          output bit hit, output int lat, output bit stable, output bit idle_after);
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_op      = ins;
        bus.ip_protocol = k.ip_protocol;
        bus.src_port    = k.src_port;
        bus.dst_port    = k.dst_port;
        bus.rsp_ready   = early_ready;
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        bus.rsp_ready = 1'b0;
        hit    = bus.rsp_hit;
        stable = (bus.rsp_valid === 1'b1) && (bus.req_ready === 1'b0);
        repeat (hold) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_hit !== hit || bus.req_ready !== 1'b0) stable = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        idle_after = (bus.rsp_valid === 1'b0) && (bus.req_ready === 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_hit !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: rsp_valid=%b rsp_hit=%b busy=%b req_ready=%b, want 0 0 0 1",
                     bus.rsp_valid, bus.rsp_hit, busy, bus.req_ready);
        end
        checks++;
        if (occupancy !== '0 || hit_count !== '0 || insert_count !== '0 || dut.bits_q !== '0) begin
            errors++;
            $display("FAIL reset_state: occ=%0d hits=%0d ins=%0d bits_zero=%b, want all zero",
                     occupancy, hit_count, insert_count, dut.bits_q == '0);
        end
    endtask

    task automatic test_query_insert();
        flow_key_t k;
        bit hit, stable, idle_after, exp;
        int lat;
        k = '{ip_protocol: 72'h0A000001_0A000002_06, src_port: 16'd80, dst_port: 16'd443};
        // rsp_ready held high while no response is pending must be ignored.
        run_op(1'b0, k, 0, 1'b1, hit, lat, stable, idle_after);
        model_apply(1'b0, k, exp);
        checks++;
        if (lat !== K_HASH) begin
            errors++;
            $display("FAIL query_latency: got %0d edges, want %0d", lat, K_HASH);
        end
        checks++;
        if (hit !== 1'b0 || hit_count !== '0 || !idle_after) begin
            errors++;
            $display("FAIL empty_query: hit=%b hit_count=%0d idle=%b, want 0 0 1", hit, hit_count, idle_after);
        end
        run_op(1'b1, k, 0, 1'b0, hit, lat, stable, idle_after);
        model_apply(1'b1, k, exp);
        checks++;
        if (hit !== 1'b0 || insert_count !== CNT_W'(1) || occupancy !== (IDX_W+1)'(model_occ)) begin
            errors++;
            $display("FAIL first_insert: hit=%b ins=%0d occ=%0d, want 0 1 %0d", hit, insert_count, occupancy, model_occ);
        end
        run_op(1'b0, k, 0, 1'b0, hit, lat, stable, idle_after);
        model_apply(1'b0, k, exp);
        checks++;
        if (hit !== 1'b1 || hit_count !== CNT_W'(1)) begin
            errors++;
            $display("FAIL query_after_insert: hit=%b hit_count=%0d, want 1 1", hit, hit_count);
        end
    endtask

    task automatic test_hold();
        flow_key_t k;
        bit hit, stable, idle_after, exp;
        int lat;
        k = '{ip_protocol: 72'h0A000001_0A000002_06, src_port: 16'd80, dst_port: 16'd443};
        run_op(1'b0, k, 5, 1'b0, hit, lat, stable, idle_after);
        model_apply(1'b0, k, exp);
        checks++;
        if (!stable || hit !== exp) begin
            errors++;
            $display("FAIL hold_stable: stable=%b hit=%b, want 1 %b", stable, hit, exp);
        end
        checks++;
        if (!idle_after || hit_count !== CNT_W'(model_hits)) begin
            errors++;
            $display("FAIL hold_complete: idle=%b hit_count=%0d, want 1 %0d", idle_after, hit_count, model_hits);
        end
    endtask

    task automatic test_random();
        flow_key_t k;
        bit hit, stable, idle_after, exp, from_set;
        int lat;
        do_reset();
        keys.delete();
        for (int n = 0; n < 200; n++) begin
            k = rand_key();
            keys.push_back(k);
            run_op(1'b1, k, $urandom_range(0, 2), 1'b0, hit, lat, stable, idle_after);
            model_apply(1'b1, k, exp);
            checks++;
            if (hit !== exp || occupancy !== (IDX_W+1)'(model_occ) || lat !== K_HASH) begin
                errors++;
                $display("FAIL rand_insert[%0d]: hit=%b occ=%0d lat=%0d, want %b %0d %0d",
                         n, hit, occupancy, lat, exp, model_occ, K_HASH);
            end
        end
        for (int n = 0; n < 200; n++) begin
            from_set = $urandom_range(0, 1) == 1;
            k = from_set ? keys[$urandom_range(0, keys.size() - 1)] : rand_key();
            run_op(1'b0, k, $urandom_range(0, 2), 1'b0, hit, lat, stable, idle_after);
            model_apply(1'b0, k, exp);
            checks++;
            if (hit !== exp || (from_set && hit !== 1'b1)) begin
                errors++;
                $display("FAIL rand_query[%0d]: hit=%b, want %b (inserted=%b)", n, hit, exp, from_set);
            end
        end
        checks++;
        if (insert_count !== CNT_W'(200) || hit_count !== CNT_W'(model_hits)) begin
            errors++;
            $display("FAIL rand_counters: ins=%0d hits=%0d, want 200 %0d", insert_count, hit_count, model_hits);
        end
        checks++;
        if (dut.bits_q !== model_vec()) begin
            errors++;
            $display("FAIL rand_array: bit array differs from model");
        end
    endtask

    task automatic test_clear_priority();
        flow_key_t k;
        bit hit, exp, ready_at_start;
        int n, lat;
        k = keys[0];
        @(negedge clk);
        clear_req       = 1'b1;
        bus.req_valid   = 1'b1;
        bus.req_op      = 1'b0;
        bus.ip_protocol = k.ip_protocol;
        bus.src_port    = k.src_port;
        bus.dst_port    = k.dst_port;
        @(negedge clk);
        ready_at_start = bus.req_ready;
        n = 0;
        while (busy === 1'b1 && n < LIMIT) begin
            n++;
            @(negedge clk);
            clear_req = 1'b0;
        end
        clear_req = 1'b0;
        model_clear();
        checks++;
        if (n !== N_WORDS || ready_at_start !== 1'b0) begin
            errors++;
            $display("FAIL clear_busy: busy cycles=%0d req_ready=%b, want %0d 0", n, ready_at_start, N_WORDS);
        end
        checks++;
        if (occupancy !== '0 || hit_count !== '0 || insert_count !== '0 || dut.bits_q !== '0) begin
            errors++;
            $display("FAIL clear_state: occ=%0d hits=%0d ins=%0d, want all zero", occupancy, hit_count, insert_count);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 0;
        while (bus.rsp_valid !== 1'b1 && lat < LIMIT) begin
            @(negedge clk);
            lat++;
        end
        hit = bus.rsp_hit;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        model_apply(1'b0, k, exp);
        checks++;
        if (lat !== K_HASH || hit !== exp || hit !== 1'b0) begin
            errors++;
            $display("FAIL held_query: lat=%0d hit=%b, want %0d 0", lat, hit, K_HASH);
        end
    endtask

    task automatic test_reset_mid_probe();
        flow_key_t k;
        k = rand_key();
        @(negedge clk);
        bus.req_valid   = 1'b1;
        bus.req_op      = 1'b1;
        bus.ip_protocol = k.ip_protocol;
        bus.src_port    = k.src_port;
        bus.dst_port    = k.dst_port;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        checks++;
        if (busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1
            || occupancy !== '0 || dut.bits_q !== '0) begin
            errors++;
            $display("FAIL reset_mid_probe: busy=%b rsp_valid=%b req_ready=%b occ=%0d, want 0 0 1 0",
                     busy, bus.rsp_valid, bus.req_ready, occupancy);
        end
    endtask

    task automatic test_saturation();
        flow_key_t k;
        bit hit, stable, idle_after, exp, all_hit;
        int lat;
        k = rand_key();
        run_op(1'b1, k, 0, 1'b0, hit, lat, stable, idle_after);
        model_apply(1'b1, k, exp);
        all_hit = 1'b1;
        for (int n = 0; n < CNT_MAX - 1; n++) begin
            run_op(1'b0, k, 0, 1'b0, hit, lat, stable, idle_after);
            model_apply(1'b0, k, exp);
            if (hit !== 1'b1) all_hit = 1'b0;
        end
        checks++;
        if (hit_count !== CNT_W'(CNT_MAX - 1) || !all_hit) begin
            errors++;
            $display("FAIL sat_below: hit_count=%0d all_hit=%b, want %0d 1", hit_count, all_hit, CNT_MAX - 1);
        end
        repeat (2) begin
            run_op(1'b0, k, 0, 1'b0, hit, lat, stable, idle_after);
            model_apply(1'b0, k, exp);
        end
        checks++;
        if (hit_count !== CNT_W'(CNT_MAX) || hit_count !== CNT_W'(model_hits)) begin
            errors++;
            $display("FAIL sat_top: hit_count=%0d, want %0d", hit_count, CNT_MAX);
        end
    endtask

    initial begin
        reset           = 1'b1;
        clear_req       = 1'b0;
        bus.req_valid   = 1'b0;
        bus.req_op      = 1'b0;
        bus.ip_protocol = '0;
        bus.src_port    = '0;
        bus.dst_port    = '0;
        bus.rsp_ready   = 1'b0;
        test_reset();
        test_query_insert();
        test_hold();
        test_random();
        test_clear_priority();
        test_reset_mid_probe();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
